// File: rtl/gc_scan_ctrl.sv
// Scan-chain sequencer: optional functional capture, then a CHAIN_LEN-cycle
// shift that loads wr_data through scan_si while unloading scan_so into rd_data.
module gc_scan_ctrl #(
  parameter int CHAIN_LEN = 32,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 scan_se,
  output logic                 scan_en,
  output logic                 scan_si,
  input  logic                 scan_so
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  logic [1:0]           state_reg;
  logic [CHAIN_LEN-1:0] load_reg;
  logic [CHAIN_LEN-1:0] unload_reg;
  logic [CHAIN_LEN-1:0] rd_data_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 se_reg;
  logic                 en_reg;

  // se/en are set together with the state they belong to, so they come
  // straight from flops and never glitch on the chain's control pins.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_reg   <= ST_IDLE;
      load_reg    <= '0;
      unload_reg  <= '0;
      rd_data_reg <= '0;
      cnt_reg     <= '0;
      se_reg      <= 1'b0;
      en_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          se_reg <= 1'b0;
          en_reg <= 1'b0;
          if (start) begin
            load_reg <= wr_data;
            cnt_reg  <= '0;
            en_reg   <= 1'b1;
            if (capture_en) begin
              state_reg <= ST_CAPTURE;
            end else begin
              state_reg <= ST_SHIFT;
              se_reg    <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            se_reg    <= 1'b0;
            en_reg    <= 1'b0;
          end else begin
            state_reg <= ST_SHIFT;
            se_reg    <= 1'b1;
            en_reg    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          load_reg   <= load_reg >> 1;
          unload_reg <= {scan_so, unload_reg[CHAIN_LEN-1:1]};
          cnt_reg    <= cnt_reg + CNT_W'(1);
          // abort wins over the final-bit transition into DONE
          if (abort) begin
            state_reg <= ST_IDLE;
            se_reg    <= 1'b0;
            en_reg    <= 1'b0;
          end else if (cnt_reg == LAST_CNT) begin
            state_reg <= ST_DONE;
            se_reg    <= 1'b0;
            en_reg    <= 1'b0;
          end
        end
        default: begin
          rd_data_reg <= unload_reg;
          state_reg   <= ST_IDLE;
          se_reg      <= 1'b0;
          en_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign scan_se = se_reg;
  assign scan_en = en_reg;
  assign scan_si = (state_reg == ST_SHIFT) & load_reg[0];
  assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_gc_scan_ctrl.sv
// Scoreboard bench for gc_scan_ctrl with an 8-flop behavioural scan chain;
// the driver queues expected pass results, a monitor checks them on done.
module tb_gc_scan_ctrl;

  localparam int N = 8;

  logic         C = 1'b0;
  logic         R = 1'b0;
  logic         start = 1'b0;
  logic         capture_en = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] rd_data;
  logic         scan_se;
  logic         scan_en;
  logic         scan_si;
  logic         scan_so;

  logic [N-1:0] chain = 8'h3C;
  logic [N-1:0] d_in = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int se_cnt = 0;
  int cap_cnt = 0;
  int done_total = 0;

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] ch;
    int           start_cyc;
    int           lat;
    int           se;
    int           cap;
  } exp_t;

  exp_t q[$];

  gc_scan_ctrl #(.CHAIN_LEN(N)) dut (
    .C(C), .R(R), .start(start), .capture_en(capture_en), .abort(abort),
    .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
    .scan_se(scan_se), .scan_en(scan_en), .scan_si(scan_si), .scan_so(scan_so)
  );

  always #5 C = ~C;

  always @(posedge C) cyc <= cyc + 1;

  // Behavioural chain: index N-1 takes SI, index 0 drives SO.
  always @(posedge C) begin
    if (scan_en) chain <= scan_se ? {scan_si, chain[N-1:1]} : d_in;
  end
  assign scan_so = chain[0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: per-pass cycle counters, pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge C);
      if (!busy) begin
        se_cnt  = 0;
        cap_cnt = 0;
      end
      if (scan_se) se_cnt++;
      if (scan_en && !scan_se) cap_cnt++;
      if (done) begin
        done_total++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc - e.start_cyc + 1, e.lat);
          chk("shift_cycles", se_cnt, e.se);
          chk("capture_cycles", cap_cnt, e.cap);
          chk("chain_after_pass", chain, e.ch);
          @(negedge C);
          chk("rd_data", rd_data, e.rd);
          $display("pass done: rd_data=%02h chain=%02h (req rd=%02h chain=%02h)",
                   rd_data, chain, e.rd, e.ch);
          se_cnt  = 0;
          cap_cnt = 0;
        end
      end
    end
  end

  task automatic start_pass(input logic [N-1:0] wr, input bit cap, input logic [N-1:0] d,
                            input bit push, input logic [N-1:0] erd, input logic [N-1:0] ech,
                            input int lat, input int cap_cycles, input bit hold);
    exp_t e;
    @(negedge C);
    wr_data = wr;
    capture_en = cap;
    d_in = d;
    start = 1'b1;
    @(posedge C);
    #1;
    if (push) begin
      e.rd = erd; e.ch = ech; e.start_cyc = cyc; e.lat = lat; e.se = N; e.cap = cap_cycles;
      q.push_back(e);
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge C);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dc0;
    exp_t e;
    // Reset state
    repeat (2) @(negedge C);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_se", scan_se, 0);
    chk("rst_en", scan_en, 0);
    chk("rst_rd", rd_data, 0);
    R = 1'b1;
    @(negedge C);
    chk("idle_busy", busy, 0);
    chk("idle_si", scan_si, 0);

    // Basic load, no capture
    start_pass(8'hA5, 1'b0, 8'h00, 1'b1, 8'h3C, 8'hA5, N + 1, 0, 1'b0);
    wait_done();

    // Capture pass
    start_pass(8'h66, 1'b1, 8'h0F, 1'b1, 8'h0F, 8'h66, N + 2, 1, 1'b0);
    wait_done();

    // Back-to-back: start in DONE is ignored, start in next IDLE runs
    start_pass(8'h5A, 1'b0, 8'h00, 1'b1, 8'h66, 8'h5A, N + 1, 0, 1'b0);
    wait_done();
    start = 1'b1;
    wr_data = 8'hC3;
    capture_en = 1'b0;
    @(posedge C);
    @(negedge C);
    chk("start_in_done_ignored", busy, 0);
    @(posedge C);
    #1;
    e.rd = 8'h5A; e.ch = 8'hC3; e.start_cyc = cyc; e.lat = N + 1; e.se = N; e.cap = 0;
    q.push_back(e);
    start = 1'b0;
    repeat (4) @(negedge C);
    chk("rd_held_mid_pass", rd_data, 8'h66);
    wait_done();

    // Abort in 4th shift cycle: 4 ones shifted into 0xC3 -> 0xFC
    dc0 = done_total;
    start_pass(8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
    repeat (3) @(posedge C);
    @(negedge C);
    abort = 1'b1;
    @(posedge C);
    #1;
    abort = 1'b0;
    @(negedge C);
    chk("abort_se", scan_se, 0);
    chk("abort_en", scan_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_chain", chain, 8'hFC);
    repeat (15) @(negedge C);
    chk("abort_no_done", done_total - dc0, 0);
    chk("abort_rd_kept", rd_data, 8'h5A);

    // Start held high through an entire pass
    dc0 = done_total;
    start_pass(8'h81, 1'b0, 8'h00, 1'b1, 8'hFC, 8'h81, N + 1, 0, 1'b1);
    wait_done();
    start = 1'b0;
    repeat (3) @(negedge C);
    chk("busy_ignore_one_done", done_total - dc0, 1);
    chk("busy_ignore_idle", busy, 0);

    // Asynchronous reset mid-shift
    start_pass(8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
    repeat (3) @(negedge C);
    chk("pre_reset_si", scan_si, 1);
    #2;
    R = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_se", scan_se, 0);
    chk("async_rst_en", scan_en, 0);
    chk("async_rst_si", scan_si, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_rd", rd_data, 0);
    @(negedge C);
    R = 1'b1;
    @(posedge C);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_se", scan_se, 0);
    repeat (12) @(negedge C);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
